// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: serializes buffered left/right sample pairs onto sdata/lrck,
// using bclk falling edges (detected on clk_in) as the bit strobe.
module i2s_tx #(
    parameter int DW = 32
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          bclk,
    input  logic          en,
    input  logic [DW-1:0] din_l,
    input  logic [DW-1:0] din_r,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          lrck,
    output logic          sdata,
    output logic          underrun
);
    localparam int FW = 2 * DW;
    localparam int CW = $clog2(FW);

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          bclk_q;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [FW-1:0] sr;
    pair_t         hold_q;
    logic          buf_full;
    logic          accept;
    logic          load;

    assign fall      = bclk_q & ~bclk;
    assign cnt_nx    = cnt + CW'(1);
    // The frame is loaded when the count steps onto 1, giving the one-bit delay after lrck.
    assign load      = en & fall & (cnt_nx == CW'(1));
    assign din_ready = ~buf_full;
    assign accept    = din_valid & ~buf_full;
    assign sdata     = sr[FW-1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) bclk_q <= 1'b0;
        else        bclk_q <= bclk;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sr       <= '0;
            lrck     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= load & ~buf_full;
            if (!en) begin
                cnt  <= '0;
                sr   <= '0;
                lrck <= 1'b0;
            end else if (fall) begin
                cnt  <= cnt_nx;
                lrck <= cnt_nx[CW-1];
                if (cnt_nx == CW'(1)) sr <= buf_full ? FW'(hold_q) : '0;
                else                  sr <= {sr[FW-2:0], 1'b0};
            end
        end
    end

    // A pair accepted in the same cycle as a load is kept for the following frame.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            hold_q   <= '0;
        end else begin
            buf_full <= (buf_full & ~load) | accept;
            if (accept) hold_q <= '{l: din_l, r: din_r};
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: bclk is generated here as clk_in/(2*half), frames are
// captured on bclk rises and compared against hand-computed sample words.
module tb_i2s_tx;
    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        bclk;
    logic        en;
    logic [31:0] din_l, din_r;
    logic        din_valid;
    logic        din_ready, lrck, sdata, underrun;

    int vectors = 0, miscompares = 0;
    int half = 4, hc = 0, rises = 0, late_cnt = 0, ur_cnt = 0;
    bit run = 0;
    logic sd_prev = 1'b0, lr_prev = 1'b0;
    logic [63:0] cap_d = '0, cap_l = '0;
    logic [63:0] fr_d[$], fr_l[$];
    int ur0, late0, r0;

    localparam logic [63:0] LR_PAT = 64'h0000_0001_FFFF_FFFE;

    i2s_tx #(.DW(32)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .bclk(bclk), .en(en),
        .din_l(din_l), .din_r(din_r), .din_valid(din_valid), .din_ready(din_ready),
        .lrck(lrck), .sdata(sdata), .underrun(underrun)
    );

    initial forever #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (underrun) ur_cnt++;

    // bclk source plus capture of sdata/lrck at each rise
    initial begin
        bclk = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!run) begin
                hc = 0; bclk = 1'b0; rises = 0;
            end else begin
                hc++;
                if (hc >= half) begin
                    hc = 0;
                    bclk = ~bclk;
                    if (bclk) begin
                        rises++;
                        if (sdata !== sd_prev || lrck !== lr_prev) late_cnt++;
                        cap_d = {cap_d[62:0], sdata};
                        cap_l = {cap_l[62:0], lrck};
                        if (rises >= 65 && (rises - 65) % 64 == 0) begin
                            fr_d.push_back(cap_d);
                            fr_l.push_back(cap_l);
                        end
                    end
                end
            end
            sd_prev = sdata;
            lr_prev = lrck;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rises < n && t < 40000) begin
            @(posedge clk_in);
            t++;
        end
        chk("wait_rises", 64'(rises >= n), 64'd1);
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r, input bit last);
        int t = 0;
        @(negedge clk_in);
        din_l = l; din_r = r; din_valid = 1'b1;
        while (!din_ready && t < 4000) begin
            @(negedge clk_in);
            t++;
        end
        chk("push_accept", 64'(din_ready), 64'd1);
        @(posedge clk_in);
        if (last) begin
            @(negedge clk_in);
            din_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; din_l = '0; din_r = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_lrck", 64'(lrck), 64'd0);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_ready", 64'(din_ready), 64'd1);
        chk("rst_underrun", 64'(underrun), 64'd0);

        // basic frame at clk_in/8
        rst_n = 1'b1; en = 1'b1;
        push(32'hA5A5_0001, 32'h8000_00FF, 1'b1);
        chk("ready_after_push", 64'(din_ready), 64'd0);
        run = 1'b1;
        wait_rises(65);
        chk("f0_data", fr_d[0], {32'hA5A5_0001, 32'h8000_00FF});
        chk("f0_lrck", fr_l[0], LR_PAT);
        chk("f0_no_underrun", 64'(ur_cnt), 64'd0);
        chk("ready_after_load", 64'(din_ready), 64'd1);

        // underrun frame, with a pair pushed mid-frame
        wait_rises(90);
        push(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_rises(129);
        chk("f1_silence", fr_d[1], 64'd0);
        chk("f1_underrun", 64'(ur_cnt), 64'd1);
        chk("ready_held_low", 64'(din_ready), 64'd0);
        wait_rises(193);
        chk("f2_data", fr_d[2], {32'h1234_5678, 32'h9ABC_DEF0});
        chk("f2_lrck", fr_l[2], LR_PAT);

        // back-to-back stream, din_valid held high
        for (int k = 0; k < 4; k++)
            push(32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), k == 3);
        push(32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1);
        wait_rises(449);
        chk("frame_count", 64'(fr_d.size()), 64'd7);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_data", fr_d[3+k], {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)});
            chk("b2b_lrck", fr_l[3+k], LR_PAT);
        end
        chk("b2b_no_underrun", 64'(ur_cnt), 64'd1);

        // enable toggle at c = 40 with a pair buffered
        push(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
        wait_rises(489);
        @(negedge clk_in);
        chk("pre_dis_lrck", 64'(lrck), 64'd1);
        chk("pre_dis_sdata", 64'(sdata), 64'd1);
        en = 1'b0;
        @(negedge clk_in);
        chk("dis_lrck", 64'(lrck), 64'd0);
        chk("dis_sdata", 64'(sdata), 64'd0);
        chk("dis_buf_kept", 64'(din_ready), 64'd0);
        wait_rises(500);
        @(negedge clk_in);
        en = 1'b1;
        wait_rises(564);
        chk("reen_data", cap_d, {32'hDEAD_BEEF, 32'hCAFE_F00D});
        chk("reen_lrck", cap_l, LR_PAT);
        chk("reen_no_underrun", 64'(ur_cnt), 64'd1);

        // async reset at c = 20 with the buffer full
        push(32'h1111_1111, 32'h2222_2222, 1'b1);
        wait_rises(566);
        push(32'h3333_3333, 32'h4444_4444, 1'b1);
        wait_rises(584);
        chk("pre_rst_sdata", 64'(sdata), 64'd1);
        chk("pre_rst_ready", 64'(din_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sdata", 64'(sdata), 64'd0);
        chk("arst_lrck", 64'(lrck), 64'd0);
        chk("arst_ready", 64'(din_ready), 64'd1);
        rst_n = 1'b1;
        r0 = rises;
        wait_rises(r0 + 64);
        chk("post_rst_silence", cap_d, 64'd0);
        chk("post_rst_underrun", 64'(ur_cnt), 64'd2);

        // divider settings clk_in/4 then clk_in/16
        for (int d = 0; d < 2; d++) begin
            @(negedge clk_in);
            rst_n = 1'b0; run = 1'b0;
            repeat (3) @(negedge clk_in);
            half = (d == 0) ? 2 : 8;
            rst_n = 1'b1;
            ur0 = ur_cnt;
            late0 = late_cnt;
            if (d == 0) push(32'h8000_0001, 32'h7FFF_FFFE, 1'b1);
            else        push(32'hC3C3_C3C3, 32'h3C3C_3C3C, 1'b1);
            run = 1'b1;
            wait_rises(65);
            chk("div_data", cap_d, (d == 0) ? {32'h8000_0001, 32'h7FFF_FFFE}
                                            : {32'hC3C3_C3C3, 32'h3C3C_3C3C});
            chk("div_lrck", cap_l, LR_PAT);
            chk("div_no_underrun", 64'(ur_cnt - ur0), 64'd0);
            chk("div_setup_margin", 64'(late_cnt - late0), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
